// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the datapath select/control codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_JALR_TGT,
        S_JALR_LINK,
        S_BRANCH,
        S_LUI
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_J = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded IR fields and ALU flags in,
// every select and enable out. master is the controller side.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       neg;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, neg, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, neg, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation from funct fields for R/I-type execution; the FSM
// overrides this with add/sub/pass-B outside EXECR/EXECI.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control_o = ALU_SLT;
            3'b100:  alu_control_o = ALU_XOR;
            3'b110:  alu_control_o = ALU_OR;
            3'b111:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, memory,
// register file and PC per instruction, stalling on mem_ready.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    state_t     state_q, state_d;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_ctrl, alu_dec, imm_src;
    logic       branch_taken;

    alu_decoder u_alu_decoder (
        .op5_i         (bus.op[5]),
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .alu_control_o (alu_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  branch_taken = bus.zero;
            3'b001:  branch_taken = ~bus.zero;
            3'b100:  branch_taken = bus.neg;
            3'b101:  branch_taken = ~bus.neg;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMM_I;
            OP_STORE:                   imm_src = IMM_S;
            OP_BRANCH:                  imm_src = IMM_B;
            OP_JAL:                     imm_src = IMM_J;
            OP_LUI:                     imm_src = IMM_U;
            default:                    imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_TGT;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_ctrl  = alu_dec;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = alu_dec;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            // PC takes the target held in ALUOut while OldPC+4 is formed for rd
            S_JAL, S_JALR_LINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR_TGT: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JALR_LINK;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_ctrl  = ALU_SUB;
                pc_write  = branch_taken;
                state_d   = S_FETCH;
            end
            S_LUI: begin
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_PASSB;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked while reset is held; the state register already shows FETCH.
    assign bus.PCWrite    = pc_write  & rst;
    assign bus.IRWrite    = ir_write  & rst;
    assign bus.RegWrite   = reg_write & rst;
    assign bus.MemWrite   = mem_write & rst;
    assign bus.illegal    = illegal   & rst;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_ctrl;
    assign bus.ImmSrc     = imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle control pattern and compared cycle by cycle.
module tb_multicycle_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [17:0] v;
        bit          wt;
        bit          fetch;
        int          tg;
    } rec_t;

    function automatic string tag_name(input int t);
        case (t)
            0:  return "fetch";
            1:  return "decode";
            2:  return "memadr";
            3:  return "memread";
            4:  return "memwb";
            5:  return "memwrite";
            6:  return "exec";
            7:  return "aluwb";
            8:  return "jump_link";
            9:  return "jalr_tgt";
            10: return "branch";
            11: return "lui";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [17:0] pk(input bit pcw, input bit adr, input bit mw,
                                       input bit irw, input bit rw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [2:0] imm,
                                       input bit ill);
        return {pcw, adr, mw, irw, rw, res, a, b, alu, imm, ill};
    endfunction

    function automatic rec_t mk(input logic [17:0] v, input bit wt, input bit fetch, input int tg);
        rec_t r;
        r.v = v; r.wt = wt; r.fetch = fetch; r.tg = tg;
        return r;
    endfunction

    function automatic logic [17:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ALU operation an R/I instruction asks for, by mnemonic
    function automatic logic [2:0] funct_op(input logic [2:0] f3, input bit is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Runs one instruction from FETCH. sf/sm: mem_ready-low cycles in fetch
    // and in the data access. ab >= 0 asserts reset at that cycle instead.
    task automatic run_instr(input logic [31:0] ins, input int unsigned sf, input int unsigned sm,
                             input bit z, input bit n, input int ab);
        rec_t        q[$];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [2:0]  imm;
        logic [17:0] e;
        bit          taken, mr, ill;
        int          cyc;
        int unsigned stalls;
        op  = ins[6:0];
        f3  = ins[14:12];
        ill = 1'b0;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: imm = 3'b000;
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b011;
            7'b1101111: imm = 3'b010;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = n;
            3'b101:  taken = !n;
            default: taken = 1'b0;
        endcase
        if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                         7'b1100111, 7'b1100011, 7'b0110111}))
            ill = 1'b1;

        q.push_back(mk(pk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,imm,0), 1, 1, 0));
        q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,ill), 0, 0, 1));
        case (op)
            7'b0000011: begin
                q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,imm,0), 0, 0, 2));
                q.push_back(mk(pk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,imm,0), 1, 0, 3));
                q.push_back(mk(pk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,imm,0), 0, 0, 4));
            end
            7'b0100011: begin
                q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,imm,0), 0, 0, 2));
                q.push_back(mk(pk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,imm,0), 1, 0, 5));
            end
            7'b0110011: begin
                q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b10,2'b00,funct_op(f3, ins[30]),imm,0), 0, 0, 6));
                q.push_back(mk(pk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,imm,0), 0, 0, 7));
            end
            7'b0010011: begin
                q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b10,2'b01,funct_op(f3, 1'b0),imm,0), 0, 0, 6));
                q.push_back(mk(pk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,imm,0), 0, 0, 7));
            end
            7'b1101111: begin
                q.push_back(mk(pk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,imm,0), 0, 0, 8));
                q.push_back(mk(pk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,imm,0), 0, 0, 7));
            end
            7'b1100111: begin
                q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,imm,0), 0, 0, 9));
                q.push_back(mk(pk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,imm,0), 0, 0, 8));
                q.push_back(mk(pk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,imm,0), 0, 0, 7));
            end
            7'b1100011:
                q.push_back(mk(pk(taken,0,0,0,0,2'b00,2'b10,2'b00,3'b001,imm,0), 0, 0, 10));
            7'b0110111: begin
                q.push_back(mk(pk(0,0,0,0,0,2'b00,2'b00,2'b01,3'b111,imm,0), 0, 0, 11));
                q.push_back(mk(pk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,imm,0), 0, 0, 7));
            end
            default: ;
        endcase

        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = ins[30];
        cyc = 0;
        foreach (q[i]) begin
            stalls = q[i].wt ? (q[i].fetch ? sf : sm) : 0;
            for (int unsigned s = 0; s <= stalls; s++) begin
                if (cyc == ab) begin
                    bus.mem_ready = 1'b1;
                    rst = 1'b0;
                    #1;
                    check("rst_abort", observed(), pk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,imm,0));
                    @(posedge clk);
                    #1;
                    check("rst_hold", observed(), pk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,imm,0));
                    rst = 1'b1;
                    return;
                end
                mr = q[i].wt ? (s == stalls) : 1'($urandom);
                e  = q[i].v;
                if (q[i].wt && !mr && q[i].fetch) begin
                    e[17] = 1'b0;
                    e[14] = 1'b0;
                end
                bus.mem_ready = mr;
                bus.zero      = z;
                bus.neg       = n;
                #1;
                check(tag_name(q[i].tg), observed(), e);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  rop;
        logic [6:0]  ops [8];
        int unsigned k;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.op        = 7'b0110011;
        bus.funct3    = 3'b000;
        bus.funct7b5  = 1'b0;
        bus.zero      = 1'b0;
        bus.neg       = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check("reset", observed(), pk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_instr(32'h002081B3, 0, 0, 0, 0, -1);
        run_instr(32'h002081B3, 0, 0, 0, 0, 2);
        run_instr(32'h402081B3, 0, 0, 0, 0, -1);
        run_instr(32'h0000A103, 0, 3, 0, 0, -1);
        run_instr(32'h0000A103, 2, 0, 1, 1, -1);
        run_instr(32'h00208463, 0, 0, 1, 0, -1);
        run_instr(32'h00208463, 0, 0, 0, 0, -1);
        run_instr(32'h00209463, 0, 0, 0, 0, -1);
        run_instr(32'h0080006F, 0, 0, 0, 0, -1);
        run_instr(32'h123450B7, 0, 0, 0, 0, -1);
        run_instr(32'h0000007F, 0, 0, 0, 0, -1);
        run_instr(32'h0020A223, 1, 2, 0, 0, -1);
        run_instr(32'h000080E7, 0, 0, 0, 0, -1);
        run_instr(32'h40008093, 0, 0, 0, 0, -1);

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            k   = $urandom_range(0, 8);
            if (k < 8) begin
                ins[6:0] = ops[k];
            end else begin
                do begin
                    rop = 7'($urandom);
                end while (rop inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                       7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111});
                ins[6:0] = rop;
            end
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
